led_trail_pwm: RTL and testbench
================================

// Module: led_trail_pwm
// PURPOSE
//  Downstream of the knight_rider scanner. Gives each lit LED a fading "comet tail".
//  Consumes the scanner's one-hot LED pattern and keeps a per-LED brightness level.
//  A lit LED is forced to full brightness. An unlit LED decays toward 0 on a prescaled tick.
//  Levels are rendered with a shared free-running PWM counter; leds_out drives the pins.
// PARAMETERS
//  N_LEDS      8   number of LED channels
//  PWM_BITS    4   brightness width; MAX = 2**PWM_BITS-1 (full on)
//  DECAY_DIV   16  clki cycles per decay tick (>=1; 1 = tick every cycle)
//  DECAY_STEP  1   amount subtracted from an unlit level per decay tick (1..MAX)
// PORTS
//  clki        in   1          system clock, all state on rising edge
//  reset       in   1          asynchronous, active-low reset
//  pat_in      in   N_LEDS     LED pattern from scanner, bit i = LED i lit
//  pat_valid   in   1          pat_in sampled on every rising edge where this is high
//  leds_out    out  N_LEDS     PWM-modulated LED drive, registered
//  frame_start out  1          registered 1-cycle pulse at the start of each PWM frame
// BEHAVIOUR
//  Reset (reset=0, async):
//   - cur_pat=0, all level[i]=0, pwm_cnt=0, dcnt=0.
//   - leds_out=0, frame_start=0; held while reset low.
//  Effective pattern: eff = pat_valid ? pat_in : cur_pat (combinational).
//   - On each edge with pat_valid=1: cur_pat <= pat_in.
//   - No backpressure; a new pat_valid overrides the previous pattern immediately.
//  Decay prescaler:
//   - dcnt counts 0..DECAY_DIV-1 and wraps.
//   - tick=1 in the cycle where dcnt==DECAY_DIV-1.
//  Level update, per edge, per channel i, in priority order:
//   1. eff[i]=1 -> level[i] <= MAX (relight wins over decay, even on tick).
//   2. else tick=1 -> level[i] <= (level[i] < DECAY_STEP) ? 0 : level[i]-DECAY_STEP.
//   3. else hold.
//   - Level never wraps below 0 and never exceeds MAX.
//  PWM:
//   - pwm_cnt counts 0..MAX-1 and wraps to 0; frame period = MAX cycles.
//   - leds_out[i] <= (level[i] > pwm_cnt), registered.
//   - level MAX -> always 1; level 0 -> always 0; level L -> high L of MAX cycles per frame.
//   - frame_start <= (pwm_cnt==MAX-1): high for the first cycle of each frame
//     (the cycle where the registered compare uses pwm_cnt=0).
//  Latency:
//   - pat_valid with pat_in[i]=1 sampled at edge k -> level[i]=MAX after k;
//     leds_out[i]=1 after edge k+1 and stays 1 while lit.
//  Fade time: unlit channel from MAX reaches 0 after ceil(MAX/DECAY_STEP) ticks.
//  Reset mid-fade: all levels and outputs clear immediately; after release, PWM and
//   prescaler restart from 0 on the first edge.
//  Multiple pattern bits set are legal; each channel is independent.
// TESTING  (N_LEDS=8, PWM_BITS=4 -> MAX=15, DECAY_DIV=4, DECAY_STEP=1 unless noted)
//  1. Reset low mid-run -> leds_out=0, frame_start=0 at once; release -> frame_start first
//     high 15 cycles later, then every 15 cycles.
//  2. pat_valid=1, pat_in=8'h01 at edge k -> leds_out=8'h01 from edge k+1, continuously;
//     other bits 0.
//  3. After (2), pat_valid with 8'h02 -> bit1 solid on; bit0 level 15->14 on next tick
//     (14 of 15 cycles high); bit0 reaches 0 after 15 ticks (60 cycles), then stays 0.
//  4. Bit0 fading at level 7, pat_in=8'h01 re-applied on a tick cycle -> level 15
//     (relight beats decay), leds_out[0] solid 1 from next edge.
//  5. DECAY_STEP=4: unlit channel levels 15,11,7,3,0 on successive ticks -> saturates at 0,
//     no wrap to 15.
//  6. DECAY_DIV=1, pat_in=8'hFF then 8'h00 -> all levels step down each cycle;
//     leds_out all 0 within 16 cycles; frame_start period unaffected.

Source files
------------

// File: rtl/led_trail_pwm_if.sv
// led_trail_pwm_if
//  Bundles the scanner-facing pattern input and the LED-facing outputs of
//  led_trail_pwm into one interface.
//  Signals:
//   pat_in      N_LEDS  LED pattern from the scanner, bit i = LED i lit
//   pat_valid   1       pat_in is taken on every rising edge where this is high
//   leds_out    N_LEDS  PWM-modulated LED drive
//   frame_start 1       one-cycle pulse at the start of each PWM frame
//  Modports:
//   master  drives the pattern and observes the LED outputs (scanner / bench side)
//   slave   consumes the pattern and drives the LED outputs (led_trail_pwm side)
interface led_trail_pwm_if #(
    parameter int N_LEDS = 8
);
    logic [N_LEDS-1:0] pat_in;
    logic              pat_valid;
    logic [N_LEDS-1:0] leds_out;
    logic              frame_start;

    modport master (
        output pat_in,
        output pat_valid,
        input  leds_out,
        input  frame_start
    );

    modport slave (
        input  pat_in,
        input  pat_valid,
        output leds_out,
        output frame_start
    );
endinterface

// File: rtl/led_trail_pwm.sv
// led_trail_pwm
//  Gives each lit LED of the scanner's pattern a fading "comet tail".
//  Each channel keeps a brightness level: a lit channel jumps to full
//  brightness, an unlit one decays by DECAY_STEP on every prescaled tick and
//  saturates at zero. Levels are rendered by comparing against one shared
//  free-running PWM counter of period MAX = 2**PWM_BITS-1 cycles.
//  Ports:
//   clki   in   system clock, all state on the rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave side of led_trail_pwm_if (pat_in, pat_valid in;
//          leds_out, frame_start out, both registered)
module led_trail_pwm #(
    parameter int N_LEDS     = 8,
    parameter int PWM_BITS   = 4,
    parameter int DECAY_DIV  = 16,
    parameter int DECAY_STEP = 1
) (
    input  logic           clki,
    input  logic           reset,
    led_trail_pwm_if.slave bus
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    // PWM counter runs 0..MAX-1, so its last value is MAX-1.
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] STEP_LVL = PWM_BITS'(DECAY_STEP);
    // A divider of 1 still needs a 1-bit counter; it simply stays at 0.
    localparam int                  DCNT_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DCNT_W-1:0]   DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

    logic [N_LEDS-1:0]                cur_pat_r;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  level_r;
    logic [DCNT_W-1:0]                dcnt_r;
    logic [PWM_BITS-1:0]              pwm_cnt_r;
    logic [N_LEDS-1:0]                leds_out_r;
    logic                             frame_start_r;

    logic [N_LEDS-1:0]                eff_s;
    logic                             tick_s;
    logic [DCNT_W-1:0]                dcnt_nxt_s;
    logic [PWM_BITS-1:0]              pwm_nxt_s;
    logic [N_LEDS-1:0][PWM_BITS-1:0]  level_nxt_s;
    logic [N_LEDS-1:0]                led_cmp_s;

    // Effective pattern: a valid new pattern takes effect in the same cycle.
    always_comb begin
        if (bus.pat_valid) begin
            eff_s = bus.pat_in;
        end else begin
            eff_s = cur_pat_r;
        end
    end

    // Decay prescaler and PWM counter next-state; tick marks the last prescaler count.
    always_comb begin
        tick_s = (dcnt_r == DCNT_LAST);
        if (tick_s) begin
            dcnt_nxt_s = '0;
        end else begin
            dcnt_nxt_s = dcnt_r + DCNT_W'(1);
        end
        if (pwm_cnt_r == PWM_LAST) begin
            pwm_nxt_s = '0;
        end else begin
            pwm_nxt_s = pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // Per-channel level update (relight beats decay) and PWM compare on the current level.
    always_comb begin
        level_nxt_s = level_r;
        led_cmp_s   = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (eff_s[i]) begin
                level_nxt_s[i] = LVL_MAX;
            end else if (tick_s) begin
                // Saturating subtract so a dim channel never wraps back to bright.
                if (level_r[i] < STEP_LVL) begin
                    level_nxt_s[i] = '0;
                end else begin
                    level_nxt_s[i] = level_r[i] - STEP_LVL;
                end
            end else begin
                level_nxt_s[i] = level_r[i];
            end
            led_cmp_s[i] = (level_r[i] > pwm_cnt_r);
        end
    end

    // State and output registers.
    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            cur_pat_r     <= '0;
            level_r       <= '0;
            dcnt_r        <= '0;
            pwm_cnt_r     <= '0;
            leds_out_r    <= '0;
            frame_start_r <= 1'b0;
        end else begin
            cur_pat_r     <= eff_s;
            level_r       <= level_nxt_s;
            dcnt_r        <= dcnt_nxt_s;
            pwm_cnt_r     <= pwm_nxt_s;
            leds_out_r    <= led_cmp_s;
            // Registered compare at pwm_cnt=0 is in flight when this pulse is high.
            frame_start_r <= (pwm_cnt_r == PWM_LAST);
        end
    end

    assign bus.leds_out    = leds_out_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm
//  Three instances share clock, reset and stimulus:
//   dut_a  DECAY_DIV=4, DECAY_STEP=1
//   dut_b  DECAY_DIV=4, DECAY_STEP=4
//   dut_c  DECAY_DIV=1, DECAY_STEP=1
//  A behavioural model predicts every output after each rising edge and queues
//  it; the falling-edge monitor pops and compares. Directed checks cover
//  latency, fade time, relight-on-tick, saturation and frame timing.
module tb_led_trail_pwm;

    logic clki  = 1'b0;
    logic reset = 1'b1;

    initial forever #5 clki = ~clki;

    led_trail_pwm_if #(.N_LEDS(8)) if_a ();
    led_trail_pwm_if #(.N_LEDS(8)) if_b ();
    led_trail_pwm_if #(.N_LEDS(8)) if_c ();

    led_trail_pwm #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(1))
        dut_a (.clki(clki), .reset(reset), .bus(if_a));
    led_trail_pwm #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(4))
        dut_b (.clki(clki), .reset(reset), .bus(if_b));
    led_trail_pwm #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(1), .DECAY_STEP(1))
        dut_c (.clki(clki), .reset(reset), .bus(if_c));

    typedef struct packed {
        logic [7:0] leds;
        logic       fs;
    } out_t;

    typedef struct {
        logic       v;
        logic [7:0] p;
        int         cyc;
        logic [7:0] mask;
        logic [7:0] exp;
    } vec_t;

    out_t q_a[$];
    out_t q_b[$];
    out_t q_c[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic       tb_valid = 1'b0;
    logic [7:0] tb_pat   = 8'h00;

    int         m_level[3][8];
    logic [7:0] m_cur[3];
    int         m_pwm[3];
    int         m_dcnt[3];

    function automatic int div_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int step_of(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] p);
        tb_valid       = v;
        tb_pat         = p;
        if_a.pat_valid = v;
        if_a.pat_in    = p;
        if_b.pat_valid = v;
        if_b.pat_in    = p;
        if_c.pat_valid = v;
        if_c.pat_in    = p;
    endtask

    // One rising edge of the reference model for instance d.
    task automatic model_edge(input int d, output out_t o);
        logic [7:0] eff;
        logic       tick;
        int         nl;
        eff  = tb_valid ? tb_pat : m_cur[d];
        tick = (m_dcnt[d] == div_of(d) - 1);
        for (int i = 0; i < 8; i++) begin
            o.leds[i] = (m_level[d][i] > m_pwm[d]);
        end
        o.fs = (m_pwm[d] == 14);
        for (int i = 0; i < 8; i++) begin
            if (eff[i]) begin
                m_level[d][i] = 15;
            end else if (tick) begin
                nl = m_level[d][i] - step_of(d);
                m_level[d][i] = (nl < 0) ? 0 : nl;
            end
        end
        m_cur[d]  = eff;
        m_dcnt[d] = (m_dcnt[d] + 1) % div_of(d);
        m_pwm[d]  = (m_pwm[d] + 1) % 15;
    endtask

    // Model: predict on each rising edge, clear on reset.
    initial forever begin : model_loop
        out_t o;
        @(posedge clki or negedge reset);
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 8; i++) m_level[d][i] = 0;
                m_cur[d]  = 8'h00;
                m_pwm[d]  = 0;
                m_dcnt[d] = 0;
            end
            q_a.delete();
            q_b.delete();
            q_c.delete();
        end else begin
            model_edge(0, o);
            q_a.push_back(o);
            model_edge(1, o);
            q_b.push_back(o);
            model_edge(2, o);
            q_c.push_back(o);
        end
    end

    // Monitor: compare every instance against the queued prediction.
    initial forever begin : monitor_loop
        @(negedge clki);
        if (!reset) begin
            chk("rst_a", 32'({if_a.leds_out, if_a.frame_start}), 32'h0);
            chk("rst_b", 32'({if_b.leds_out, if_b.frame_start}), 32'h0);
            chk("rst_c", 32'({if_c.leds_out, if_c.frame_start}), 32'h0);
        end else begin
            if (q_a.size() > 0) chk("sb_a", 32'({if_a.leds_out, if_a.frame_start}), 32'(q_a.pop_front()));
            if (q_b.size() > 0) chk("sb_b", 32'({if_b.leds_out, if_b.frame_start}), 32'(q_b.pop_front()));
            if (q_c.size() > 0) chk("sb_c", 32'({if_c.leds_out, if_c.frame_start}), 32'(q_c.pop_front()));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vt[8];
        int   cnt;
        logic seen;
        logic found;
        int   first_a, second_a, first_c, second_c;

        // Solid-on / solid-off expectations for dut_a, derived by hand.
        vt[0] = '{1'b1, 8'h01,  2, 8'hFF, 8'h01};
        vt[1] = '{1'b0, 8'h00, 20, 8'hFF, 8'h01};
        vt[2] = '{1'b1, 8'h02,  2, 8'h02, 8'h02};
        vt[3] = '{1'b1, 8'h81,  2, 8'h81, 8'h81};
        vt[4] = '{1'b1, 8'h00, 80, 8'hFF, 8'h00};
        vt[5] = '{1'b1, 8'hFF,  2, 8'hFF, 8'hFF};
        vt[6] = '{1'b1, 8'h00, 70, 8'hFF, 8'h00};
        vt[7] = '{1'b0, 8'h00, 10, 8'hFF, 8'h00};

        drive(1'b0, 8'h00);
        #1 reset = 1'b0;
        repeat (3) @(negedge clki);
        chk("rst_fs_a", 32'(if_a.frame_start), 32'h0);
        #1 reset = 1'b1;

        for (int t = 0; t < 8; t++) begin
            drive(vt[t].v, vt[t].p);
            repeat (vt[t].cyc) @(negedge clki);
            chk($sformatf("vec%0d", t), 32'(if_a.leds_out & vt[t].mask), 32'(vt[t].exp));
        end

        // Latency: lit at edge k -> output high from edge k+1.
        drive(1'b1, 8'h01);
        @(negedge clki);
        chk("lat_k", 32'(if_a.leds_out), 32'h00);
        drive(1'b0, 8'h00);
        @(negedge clki);
        chk("lat_k1", 32'(if_a.leds_out), 32'h01);
        for (int j = 0; j < 30; j++) begin
            @(negedge clki);
            chk("solid0", 32'(if_a.leds_out), 32'h01);
        end

        // Override with bit1: bit0 fades out, bit1 solid; dut_b saturates at 0.
        drive(1'b1, 8'h02);
        @(negedge clki);
        drive(1'b0, 8'h00);
        seen = 1'b0;
        for (int j = 1; j <= 84; j++) begin
            @(negedge clki);
            chk("solid1", 32'(if_a.leds_out[1]), 32'h1);
            if (j >= 30 && j <= 44) seen = seen | if_a.leds_out[0];
            if (j >= 64) chk("fade0_a", 32'(if_a.leds_out[0]), 32'h0);
            if (j >= 20) chk("sat0_b", 32'(if_b.leds_out[0]), 32'h0);
        end
        chk("fade_not_early", 32'(seen), 32'h1);

        // Relight on a tick cycle while bit0 sits at level 7.
        drive(1'b1, 8'h01);
        @(negedge clki);
        drive(1'b1, 8'h00);
        @(negedge clki);
        drive(1'b0, 8'h00);
        found = 1'b0;
        for (int j = 0; j < 100 && !found; j++) begin
            @(negedge clki);
            if (m_level[0][0] == 7 && m_dcnt[0] == 3) found = 1'b1;
        end
        chk("relight_wait", 32'(found), 32'h1);
        if (found) begin
            drive(1'b1, 8'h01);
            @(negedge clki);
            drive(1'b1, 8'h00);
            cnt = 0;
            for (int j = 0; j < 15; j++) begin
                @(negedge clki);
                cnt += int'(if_a.leds_out[0]);
            end
            chk("relight_duty", 32'(cnt >= 12), 32'h1);
        end

        // Tick every cycle on dut_c: all dark within 16 cycles.
        drive(1'b1, 8'hFF);
        repeat (2) @(negedge clki);
        drive(1'b1, 8'h00);
        @(negedge clki);
        for (int j = 1; j <= 26; j++) begin
            @(negedge clki);
            if (j >= 16) chk("fast_fade_c", 32'(if_c.leds_out), 32'h00);
        end

        // Asynchronous reset mid-run, then frame timing after release.
        drive(1'b1, 8'hFF);
        repeat (3) @(negedge clki);
        @(posedge clki);
        #2 reset = 1'b0;
        #1;
        chk("async_a", 32'({if_a.leds_out, if_a.frame_start}), 32'h0);
        chk("async_c", 32'({if_c.leds_out, if_c.frame_start}), 32'h0);
        @(negedge clki);
        #1 reset = 1'b1;
        first_a = 0; second_a = 0; first_c = 0; second_c = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clki);
            if (if_a.frame_start) begin
                if (first_a == 0) first_a = j;
                else if (second_a == 0) second_a = j;
            end
            if (if_c.frame_start) begin
                if (first_c == 0) first_c = j;
                else if (second_c == 0) second_c = j;
            end
        end
        chk("fs_first_a", 32'(first_a), 32'd15);
        chk("fs_second_a", 32'(second_a), 32'd30);
        chk("fs_first_c", 32'(first_c), 32'd15);
        chk("fs_second_c", 32'(second_c), 32'd30);

        repeat (2) @(negedge clki);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
